mem_stage_lsu: RTL and testbench

- Memory-access stage: sits between the EX/MEM register and the MEM/WB register.
- Performs loads/stores over a req/gnt/rvalid data-memory bus; formats load data (size, sign); passes ALU results through for non-memory ops.
- Drives the wb_data/reg_write/rd_idx inputs of the MEM/WB register; holds the upstream pipeline via a stall output while an access is outstanding.

---
 rtl/mem_stage_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access pipeline stage between EX/MEM and MEM/WB.
// Issues loads/stores over a req/gnt/rvalid bus, formats load data by size
// and sign, and passes ALU results straight through for non-memory ops.
// Optional build macro LSU_TIMEOUT_EN adds a bus watchdog that aborts an
// access stuck in REQ or WAIT_RD for TIMEOUT_CYCLES cycles.
module mem_stage_lsu #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic              reg_write_in,
    input  logic [4:0]        rd_idx_in,
    output logic              stall,
    output logic              out_valid,
    output logic [31:0]       wb_data_out,
    output logic              reg_write_out,
    output logic [4:0]        rd_idx_out,
    output logic              misalign_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

    state_t            state_q, state_d;
    logic              capture;
    logic              misaligned;
    logic              timeout;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic              we_q;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Byte enables for an access of size sz (00 B, 01 H, else W) at byte lane.
    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand so every lane the enables select carries it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] sd);
        case (sz)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    // Pick the addressed byte/half and extend it; f3[2] selects zero-extension.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   return f3[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    assign misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                        (funct3[1] && (alu_result[1:0] != 2'b00));

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts on every state change, counts cycles spent waiting on the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the access when it leaves IDLE so the bus sees stable values until gnt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            we_q    <= 1'b0;
        end else if (capture) begin
            addr_q  <= alu_result[ADDR_W-1:0];
            be_q    <= lane_be(funct3[1:0], alu_result[1:0]);
            wdata_q <= lane_wdata(funct3[1:0], store_data);
            f3_q    <= funct3;
            rd_q    <= rd_idx_in;
            rw_q    <= reg_write_in;
            we_q    <= mem_write;
        end
    end

    // Next-state and output decode; in_valid is gated by reset so outputs read 0 in reset.
    always_comb begin
        state_d       = state_q;
        capture       = 1'b0;
        stall         = 1'b0;
        out_valid     = 1'b0;
        wb_data_out   = '0;
        reg_write_out = 1'b0;
        rd_idx_out    = '0;
        misalign_err  = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = '0;
        dmem_be       = '0;
        dmem_wdata    = '0;
        bus_err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && reset_n) begin
                    if (!(mem_read || mem_write)) begin
                        out_valid     = 1'b1;
                        wb_data_out   = alu_result;
                        reg_write_out = reg_write_in;
                        rd_idx_out    = rd_idx_in;
                    end else if (misaligned) begin
                        misalign_err = 1'b1;
                        out_valid    = 1'b1;
                        rd_idx_out   = rd_idx_in;
                    end else begin
                        stall   = 1'b1;
                        capture = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall      = 1'b1;
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                dmem_be    = be_q;
                dmem_wdata = wdata_q;
                if (dmem_gnt) begin
                    if (we_q) begin
                        stall      = 1'b0;
                        out_valid  = 1'b1;
                        rd_idx_out = rd_q;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT_RD;
                    end
                end else if (timeout) begin
                    stall      = 1'b0;
                    out_valid  = 1'b1;
                    bus_err    = 1'b1;
                    rd_idx_out = rd_q;
                    state_d    = IDLE;
                end
            end
            WAIT_RD: begin
                stall = 1'b1;
                if (dmem_rvalid) begin
                    stall         = 1'b0;
                    out_valid     = 1'b1;
                    wb_data_out   = fmt_load(f3_q, addr_q[1:0], dmem_rdata);
                    reg_write_out = rw_q;
                    rd_idx_out    = rd_q;
                    state_d       = IDLE;
                end else if (timeout) begin
                    stall      = 1'b0;
                    out_valid  = 1'b1;
                    bus_err    = 1'b1;
                    rd_idx_out = rd_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: directed cases plus randomized load/store/ALU
// traffic with random bus latencies, checked every cycle against a
// transaction-level model of the stage.
module tb_mem_stage_lsu;

`ifdef LSU_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        reg_write_in;
    logic [4:0]  rd_idx_in;
    logic        stall;
    logic        out_valid;
    logic [31:0] wb_data_out;
    logic        reg_write_out;
    logic [4:0]  rd_idx_out;
    logic        misalign_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .reg_write_in(reg_write_in), .rd_idx_in(rd_idx_in),
        .stall(stall), .out_valid(out_valid), .wb_data_out(wb_data_out),
        .reg_write_out(reg_write_out), .rd_idx_out(rd_idx_out),
        .misalign_err(misalign_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .bus_err(bus_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt = 0;

    // Per-cycle expectations, set by the driver and checked at the falling edge.
    logic        chk_en = 1'b0;
    logic        e_stall, e_ov, e_rw, e_mis, e_req, e_we, e_data_chk;
    logic [31:0] e_wb, e_addr, e_wdata;
    logic [4:0]  e_rd;
    logic [3:0]  e_be;

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---- transaction-level model ----
    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int lane, sz;
        lane = int'(a[1:0]);
        sz   = m_size(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= lane) && (i < lane + sz);
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int sz;
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        int lane, sz;
        lane = int'(a[1:0]);
        sz   = m_size(f3);
        v    = '0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = rd[8*(lane+k) +: 8];
        if (!f3[2] && sz < 4 && v[8*sz-1])
            for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    // ---- per-cycle compare ----
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'b0, stall}, {31'b0, e_stall});
            chk("out_valid", {31'b0, out_valid}, {31'b0, e_ov});
            chk("reg_write_out", {31'b0, reg_write_out}, {31'b0, e_rw});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, e_mis});
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
            chk("bus_err", {31'b0, bus_err}, 32'h0);
            if (e_data_chk) begin
                chk("wb_data_out", wb_data_out, e_wb);
                chk("rd_idx_out", {27'b0, rd_idx_out}, {27'b0, e_rd});
            end
            if (e_req) begin
                chk("dmem_addr", dmem_addr, e_addr);
                chk("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
                if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
            end
            if (stall) stall_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        e_stall = 0; e_ov = 0; e_rw = 0; e_mis = 0; e_req = 0; e_we = 0;
        e_data_chk = 0; e_wb = '0; e_addr = '0; e_wdata = '0; e_rd = '0; e_be = '0;
    endtask

    task automatic drop_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0;
        clear_exp();
    endtask

    // kind: 0 ALU op, 1 load, 2 store. g = cycles in REQ before gnt, r = cycles from gnt to rvalid.
    task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic rw, input logic [4:0] rd,
                         input int g, input int r, input logic [31:0] rdv);
        in_valid = 1; alu_result = a; store_data = sd; funct3 = f3;
        mem_read = (kind == 1); mem_write = (kind == 2);
        reg_write_in = rw; rd_idx_in = rd;
        clear_exp();
        if (kind == 0) begin
            e_ov = 1; e_data_chk = 1; e_wb = a; e_rw = rw; e_rd = rd;
            step();
        end else if (m_misal(f3, a)) begin
            e_ov = 1; e_mis = 1;
            step();
        end else begin
            e_stall = 1;
            step();
            e_req = 1; e_addr = {a[31:2], 2'b00}; e_be = m_be(f3, a);
            e_we = (kind == 2); e_wdata = m_wdata(f3, sd);
            repeat (g) step();
            dmem_gnt = 1;
            if (kind == 2) begin
                e_stall = 0; e_ov = 1;
            end
            step();
            dmem_gnt = 0;
            if (kind == 1) begin
                e_req = 0; e_we = 0;
                repeat (r - 1) step();
                dmem_rvalid = 1; dmem_rdata = rdv;
                e_stall = 0; e_ov = 1; e_rw = rw; e_rd = rd;
                e_wb = m_load(f3, a, rdv); e_data_chk = 1;
                step();
                dmem_rvalid = 0; dmem_rdata = $urandom;
            end
        end
        drop_inputs();
    endtask

    initial begin
        int s0, kind, g, r, gap, sz;
        logic [2:0] f3;
        logic [31:0] a;

        reset_n = 0; in_valid = 0; alu_result = 0; store_data = 0; mem_read = 0;
        mem_write = 0; funct3 = 0; reg_write_in = 0; rd_idx_in = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        clear_exp();

        // Model anchors.
        chk("pin_lw",  m_load(3'b010, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
        chk("pin_lb",  m_load(3'b000, 32'h103, 32'h80123456), 32'hFFFFFF80);
        chk("pin_lhu", m_load(3'b101, 32'h102, 32'hBEEF1234), 32'h0000BEEF);
        chk("pin_lbu", m_load(3'b100, 32'h103, 32'h80123456), 32'h00000080);
        chk("pin_be_sb", {28'b0, m_be(3'b000, 32'h101)}, 32'h2);
        chk("pin_be_sh", {28'b0, m_be(3'b001, 32'h102)}, 32'hC);
        chk("pin_wd_sb", m_wdata(3'b000, 32'h000000AB), 32'hABABABAB);
        chk("pin_mis_lw", {31'b0, m_misal(3'b010, 32'h102)}, 32'h1);

        // Reset state.
        #2;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_wb", wb_data_out, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
        #20 reset_n = 1;
        step();
        chk_en = 1;

        // Directed cases.
        s0 = stall_cnt;
        do_op(1, 3'b010, 32'h100, 0, 1, 5'd3, 2, 1, 32'hDEADBEEF);
        chk("lw_stall_cycles", stall_cnt - s0, 4);
        do_op(1, 3'b000, 32'h103, 0, 1, 5'd4, 0, 1, 32'h80123456);
        do_op(1, 3'b101, 32'h102, 0, 1, 5'd6, 1, 2, 32'hBEEF1234);
        do_op(1, 3'b100, 32'h103, 0, 1, 5'd7, 0, 1, 32'h80123456);
        do_op(2, 3'b000, 32'h101, 32'h000000AB, 1, 5'd8, 0, 1, 0);
        s0 = stall_cnt;
        do_op(1, 3'b010, 32'h102, 0, 1, 5'd9, 0, 1, 0);
        chk("misalign_no_stall", stall_cnt - s0, 0);
        do_op(0, 3'b000, 32'h12345678, 0, 1, 5'd5, 0, 1, 0);
        step();

        // Reset while waiting for read data.
        in_valid = 1; alu_result = 32'h140; mem_read = 1; funct3 = 3'b010;
        reg_write_in = 1; rd_idx_in = 5'd7;
        clear_exp(); e_stall = 1;
        step();
        e_req = 1; e_addr = 32'h140; e_be = 4'hF; dmem_gnt = 1;
        step();
        dmem_gnt = 0; chk_en = 0;
        #1 reset_n = 0;
        #1;
        chk("rstmid_stall", {31'b0, stall}, 32'h0);
        chk("rstmid_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rstmid_dmem_req", {31'b0, dmem_req}, 32'h0);
        chk("rstmid_reg_write", {31'b0, reg_write_out}, 32'h0);
        chk("rstmid_wb", wb_data_out, 32'h0);
        chk("rstmid_rd", {27'b0, rd_idx_out}, 32'h0);
        dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        step();
        chk("rstmid_late_rvalid", {31'b0, out_valid}, 32'h0);
        dmem_rvalid = 0;
        drop_inputs();
        reset_n = 1;
        step();
        chk_en = 1;
        do_op(1, 3'b010, 32'h100, 0, 1, 5'd3, 1, 1, 32'h01020304);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 1) f3 = ld_f3[$urandom_range(0, 4)];
            else           f3 = 3'($urandom_range(0, 2));
            a  = $urandom;
            sz = m_size(f3);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2) a[0] = 1'b0;
                if (sz == 4) a[1:0] = 2'b00;
            end
            g = $urandom_range(0, 3);
            r = $urandom_range(1, 3);
            do_op(kind, f3, a, $urandom, 1'($urandom), 5'($urandom), g, r, $urandom);
            gap = $urandom_range(0, 1);
            repeat (gap) step();
        end

`ifdef LSU_TIMEOUT_EN
        // Grant never arrives: watchdog must abort on the 8th REQ cycle.
        chk_en = 0;
        in_valid = 1; alu_result = 32'h200; mem_read = 1; funct3 = 3'b010;
        reg_write_in = 1; rd_idx_in = 5'd2;
        step();
        for (int c = 1; c <= TO; c++) begin
            chk("to_bus_err", {31'b0, bus_err}, {31'b0, c == TO});
            chk("to_stall", {31'b0, stall}, {31'b0, c != TO});
            if (c == TO) begin
                chk("to_out_valid", {31'b0, out_valid}, 32'h1);
                chk("to_reg_write", {31'b0, reg_write_out}, 32'h0);
            end
            step();
        end
        drop_inputs();
        step();
        chk("to_idle_req", {31'b0, dmem_req}, 32'h0);
        chk("to_idle_stall", {31'b0, stall}, 32'h0);
`endif

        chk_en = 0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
